// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit with a valid/ready request and
// result handshake, destination tag passthrough and exception flag.
// Ports:
//   clock, reset                 - master clock, async active-high reset
//   in_valid/in_ready            - request handshake
//   op_mult, op_div              - op select (op_mult wins)
//   operand_a, operand_b, in_tag - operands and destination tag
//   flush                        - synchronous abort to IDLE
//   out_valid/out_ready          - result handshake
//   result, exception, out_tag   - registered result bundle
//   busy                         - high while computing (RUN or FIX)
// Optional feature: define MULTDIV_EARLY_OUT_EN to finish zero-operand
// cases after a single RUN cycle (out_valid 2 edges after accept).
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_mult,
    input  logic             op_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic             accept;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             is_mult;
    logic             neg;
    logic             div_zero;
    logic             div_ovf;
    logic [TAG_W-1:0] tag_q;

    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     dtmp;
    logic [WIDTH+1:0]   ddiff;
    logic               dge;
    logic [2*WIDTH-1:0] sprod;
    logic [WIDTH:0]     ptop;
    logic               movf;
    logic [WIDTH-1:0]   quo;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == FIX);
    assign accept    = in_valid && in_ready && (op_mult || op_div)
                       && !flush;

    always_comb begin
        mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
        mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;
    end

    // One shift-add step: {carry,hi} picks up the multiplicand when the
    // current multiplier bit is set, then the whole pair shifts right.
    // One restoring-divide step: shift remainder/dividend left, subtract
    // the divisor magnitude and keep the difference if it did not borrow.
    always_comb begin
        msum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        dtmp  = {hi, lo[WIDTH-1]};
        ddiff = {1'b0, dtmp} - {2'b00, mcand};
        dge   = !ddiff[WIDTH+1];
    end

    // Product fits in signed WIDTH only if the top WIDTH+1 bits of the
    // signed double-width product are a pure sign extension.
    always_comb begin
        sprod = neg ? -{hi, lo} : {hi, lo};
        ptop  = sprod[2*WIDTH-1:WIDTH-1];
        movf  = !((&ptop) || !(|ptop));
        quo   = neg ? -lo : lo;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_nx = RUN;
                RUN:  if (cnt == CW'(WIDTH-1)) state_nx = FIX;
                FIX:  state_nx = DONE;
                DONE: begin
                    if (out_ready) begin
                        state_nx = accept ? RUN : IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            is_mult   <= 1'b0;
            neg       <= 1'b0;
            div_zero  <= 1'b0;
            div_ovf   <= 1'b0;
            tag_q     <= '0;
            result    <= '0;
            exception <= 1'b0;
            out_tag   <= '0;
        end else if (accept) begin
            is_mult  <= op_mult;
            tag_q    <= in_tag;
            hi       <= '0;
            cnt      <= '0;
            neg      <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            div_zero <= !op_mult && (operand_b == '0);
            div_ovf  <= !op_mult && (operand_a == MIN)
                        && (operand_b == '1);
            if (op_mult) begin
                mcand <= mag_a;
                lo    <= mag_b;
            end else begin
                mcand <= mag_b;
                lo    <= mag_a;
            end
`ifdef MULTDIV_EARLY_OUT_EN
            // Zero operand: clear the datapath and run a single step.
            if (operand_a == '0 || operand_b == '0) begin
                lo  <= '0;
                cnt <= CW'(WIDTH-1);
            end
`endif
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (is_mult) begin
                hi <= msum[WIDTH:1];
                lo <= {msum[0], lo[WIDTH-1:1]};
            end else begin
                hi <= dge ? ddiff[WIDTH-1:0] : dtmp[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], dge};
            end
        end else if (state == FIX && !flush) begin
            out_tag <= tag_q;
            if (is_mult) begin
                result    <= sprod[WIDTH-1:0];
                exception <= movf;
            end else if (div_zero) begin
                result    <= '0;
                exception <= 1'b1;
            end else begin
                result    <= quo;
                exception <= div_ovf;
            end
        end
    end

endmodule
